// File: rtl/quad_pkg.sv
// Shared constants for the quadrature decoder: Gray phase states, direction
// encoding, FSM states and the forward-step helper.
package quad_pkg;

    localparam logic [1:0] ST_00 = 2'b00;
    localparam logic [1:0] ST_01 = 2'b01;
    localparam logic [1:0] ST_11 = 2'b11;
    localparam logic [1:0] ST_10 = 2'b10;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        TRACK = 1'b1
    } quad_fsm_e;

    // Successor of a {A,B} state along the up sequence 00->01->11->10->00.
    function automatic logic [1:0] gray_next_up(input logic [1:0] s);
        case (s)
            ST_00:   return ST_01;
            ST_01:   return ST_11;
            ST_11:   return ST_10;
            default: return ST_00;
        endcase
    endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Two-flop synchronizer followed by a stable-count glitch filter for one phase.
// i_load bypasses the filter so the output can be seeded during start-up.
module quad_input_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic reset_in,
    input  logic i_in,
    input  logic i_load,
    output logic o_filt,
    output logic o_seed
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_filt;
    logic [CW-1:0] r_stable;

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_filt   <= 1'b0;
            r_stable <= '0;
        end else begin
            r_sync1 <= i_in;
            r_sync2 <= r_sync1;
            if (i_load) begin
                // Take the value entering sync2 so filt equals sync2 afterwards.
                r_filt   <= r_sync1;
                r_stable <= '0;
            end else if (r_sync2 != r_filt) begin
                if (r_stable == CW'(FILT_LEN - 1)) begin
                    r_filt   <= r_sync2;
                    r_stable <= '0;
                end else begin
                    r_stable <= r_stable + CW'(1);
                end
            end else begin
                r_stable <= '0;
            end
        end
    end

    assign o_filt = r_filt;
    assign o_seed = r_sync1;

endmodule

// File: rtl/quad_decoder_counter.sv
// Quadrature decoder: filters both phases, decodes Gray steps into +1/-1 and
// keeps a wrapping position count with direction and sticky error flags.
module quad_decoder_counter
    import quad_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             en,
    input  logic             clr,
    input  logic             err_clr,
    output logic [CNT_W-1:0] count_out,
    output logic             step_up,
    output logic             step_dn,
    output logic             dir_out,
    output logic             err_out
);

    quad_fsm_e        r_state;
    logic             r_init_cnt;
    logic [1:0]       r_prev;
    logic [CNT_W-1:0] r_count;
    logic             r_step_up;
    logic             r_step_dn;
    logic             r_dir;
    logic             r_err;

    logic       w_filt_a;
    logic       w_filt_b;
    logic       w_seed_a;
    logic       w_seed_b;
    logic       w_load;
    logic [1:0] w_cur;
    logic       w_up;
    logic       w_dn;
    logic       w_bad;

    assign w_load = (r_state == INIT);

    quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk      (clk),
        .reset_in (reset_in),
        .i_in     (a_in),
        .i_load   (w_load),
        .o_filt   (w_filt_a),
        .o_seed   (w_seed_a)
    );

    quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk      (clk),
        .reset_in (reset_in),
        .i_in     (b_in),
        .i_load   (w_load),
        .o_filt   (w_filt_b),
        .o_seed   (w_seed_b)
    );

    assign w_cur = {w_filt_a, w_filt_b};
    assign w_up  = (r_state == TRACK) && (w_cur == gray_next_up(r_prev));
    assign w_dn  = (r_state == TRACK) && (r_prev == gray_next_up(w_cur));
    assign w_bad = (r_state == TRACK) && ((r_prev ^ w_cur) == 2'b11);

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            r_state    <= INIT;
            r_init_cnt <= 1'b0;
            r_prev     <= ST_00;
            r_count    <= '0;
            r_step_up  <= 1'b0;
            r_step_dn  <= 1'b0;
            r_dir      <= DIR_UP;
            r_err      <= 1'b0;
        end else begin
            if (r_state == INIT) begin
                r_prev     <= {w_seed_a, w_seed_b};
                r_init_cnt <= 1'b1;
                if (r_init_cnt) begin
                    r_state <= TRACK;
                end
            end else begin
                r_prev <= w_cur;
            end

            r_step_up <= en && w_up;
            r_step_dn <= en && w_dn;

            // Clear takes priority over the count but not over the pulses.
            if (clr) begin
                r_count <= '0;
            end else if (en && w_up) begin
                r_count <= r_count + CNT_W'(1);
            end else if (en && w_dn) begin
                r_count <= r_count - CNT_W'(1);
            end

            if (en && w_up) begin
                r_dir <= DIR_UP;
            end else if (en && w_dn) begin
                r_dir <= DIR_DN;
            end

            if (w_bad) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign count_out = r_count;
    assign step_up   = r_step_up;
    assign step_dn   = r_step_dn;
    assign dir_out   = r_dir;
    assign err_out   = r_err;

endmodule

// File: doc/quad_decoder_counter.md
# quad_decoder_counter

Quadrature decoder with position counter: the receiving end of a 2-bit Gray-code up/down sequence as produced by a rotary/linear encoder or a Gray-coded 2-bit up/down counter. It synchronizes and glitch-filters two phase inputs, decodes each legal step as +1/-1, and accumulates a wrapping signed-free position count. It sits between off-chip or cross-domain encoder pins and the control logic that reads position and direction.

## Interface

- CNT_W, 16, position counter width (>= 2)
- FILT_LEN, 3, consecutive stable cycles required before a filtered phase changes (>= 1)

- clk  in  1  clock
- reset_in  in  1  reset, asynchronous, active-low
- a_in  in  1  phase A, asynchronous to clk
- b_in  in  1  phase B, asynchronous to clk
- en  in  1  count enable; low freezes count_out and suppresses step pulses
- clr  in  1  synchronous clear of count_out
- err_clr  in  1  synchronous clear of err_out
- count_out  out  CNT_W  position count
- step_up  out  1  one-cycle pulse per accepted +1 step
- step_dn  out  1  one-cycle pulse per accepted -1 step
- dir_out  out  1  direction of last accepted step, 0 = up, 1 = down
- err_out  out  1  sticky illegal-transition flag

## Operation

- Reset values: count_out 0, step_up 0, step_dn 0, dir_out 0, err_out 0, sync/filter/prev registers 0, FSM in INIT.
- Per phase: 2-FF synchronizer, then filter: stable counter increments each cycle sync2 != filtered, resets to 0 when equal; filtered <= sync2 when counter reaches FILT_LEN.
- FSM INIT: entered on reset; lasts 2 edges after reset deassertion; each edge filtered and prev <= sync2 directly, no decode, no pulses. Then TRACK.
- FSM TRACK: each cycle compare prev {A,B} to filtered {A,B}, then prev <= filtered.
  - Up sequence 00->01->11->10->00: count_out +1, step_up pulse, dir_out 0.
  - Reverse sequence: count_out -1, step_dn pulse, dir_out 1.
  - No change: nothing.
  - Both bits change (00<->11, 01<->10): err_out set, no count, no pulse, dir_out held.
- Arithmetic modulo 2^CNT_W: all-ones +1 -> 0; 0 -1 -> all-ones.
- en low: prev still tracks filtered; count_out, step_*, dir_out held/zero; err_out still sets. Re-enable causes no spurious step.
- clr and step same cycle: clr wins, count_out 0, step pulse still emitted.
- err_clr and new error same cycle: set wins.
- Reset mid-operation: all state to reset values immediately; INIT re-run.

## Timing

- Phase change meeting setup before edge 0: sync1 at edge 0, sync2 at edge 1, filtered at edge FILT_LEN+1, count_out/step_*/dir_out at edge FILT_LEN+2.
- Pulse shorter than FILT_LEN cycles after sync2: rejected, no count.
- Max step rate: one step per FILT_LEN+1 cycles per phase.
- step_up and step_dn never high in the same cycle; each high exactly one cycle per step.
- err_out rises at same edge a valid step would have counted.

## Structure

- Package quad_pkg: Gray state constants (ST_00, ST_01, ST_11, ST_10), DIR_UP/DIR_DN, FSM state enum (INIT, TRACK).
- Sub-module quad_input_filter (synchronizer + stable-count filter, parameter FILT_LEN), instantiated once per phase.
- Top holds FSM, prev register, decode, counter, flags.

## Test plan

- Reset with a_in=b_in=1 held, release -> after INIT count_out 0, no pulses, err_out 0.
- Four forward steps 00->01->11->10->00, each held 10 cycles, FILT_LEN=3 -> count_out 4, four step_up pulses each at FILT_LEN+2 edges after change, dir_out 0.
- From count 0, one reverse step 00->10 -> count_out all-ones (CNT_W=16: 16'hFFFF), step_dn pulse, dir_out 1.
- 2-cycle glitch on a_in with FILT_LEN=3 -> no count change, no pulse; then 00->11 simultaneous change -> err_out 1, count unchanged; err_clr -> err_out 0.
- en=0 during three forward steps then en=1 -> count_out unchanged, no pulses, no spurious step on re-enable; clr coincident with a step -> count_out 0, step pulse present.
- reset_in asserted mid-sequence at count 7 -> count_out 0 immediately (asynchronous), INIT re-run, counting resumes correctly.
